// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant, bounded ownership lock,
// registered per-port responses with misalignment reporting.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [2:0]            funct3_0,
    input  logic [2:0]            funct3_1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  lock0,
    input  logic                  lock1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err0,
    output logic                  err1,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } state_t;

    // Ownership spans the entry grant plus LOCK_MAX-1 locked cycles.
    localparam logic [7:0] LAST_CNT = 8'(LOCK_MAX - 1);
    localparam logic       LOCK_EN  = (LOCK_MAX > 1);

    state_t     state, state_next;
    logic [7:0] lock_cnt, lock_cnt_next;
    logic       rr_last, rr_last_next;
    logic       mis0, mis1;

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a != 2'b00));
    endfunction

    assign mis0 = misaligned(funct3_0, addr0[1:0]);
    assign mis1 = misaligned(funct3_1, addr1[1:0]);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state)
                UNLOCKED: begin
                    if (req0 && req1) begin
                        gnt0 = rr_last;
                        gnt1 = ~rr_last;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                LOCKED0: gnt0 = req0;
                LOCKED1: gnt1 = req1;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_funct3  = 3'b010;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (gnt0) begin
            mem_wr_en   = we0 & ~mis0;
            mem_funct3  = funct3_0;
            mem_addr    = addr0;
            mem_wr_data = wdata0;
        end else if (gnt1) begin
            mem_wr_en   = we1 & ~mis1;
            mem_funct3  = funct3_1;
            mem_addr    = addr1;
            mem_wr_data = wdata1;
        end
    end

    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        rr_last_next  = rr_last;
        if (gnt0) begin
            rr_last_next = 1'b0;
        end else if (gnt1) begin
            rr_last_next = 1'b1;
        end
        case (state)
            UNLOCKED: begin
                lock_cnt_next = '0;
                if (LOCK_EN && gnt0 && lock0) begin
                    state_next    = LOCKED0;
                    lock_cnt_next = 8'd1;
                end else if (LOCK_EN && gnt1 && lock1) begin
                    state_next    = LOCKED1;
                    lock_cnt_next = 8'd1;
                end
            end
            LOCKED0: begin
                lock_cnt_next = lock_cnt + 8'd1;
                if (lock_cnt >= LAST_CNT) begin
                    state_next    = UNLOCKED;
                    lock_cnt_next = '0;
                    rr_last_next  = 1'b0;
                end else if (!lock0) begin
                    state_next    = UNLOCKED;
                    lock_cnt_next = '0;
                end
            end
            LOCKED1: begin
                lock_cnt_next = lock_cnt + 8'd1;
                if (lock_cnt >= LAST_CNT) begin
                    state_next    = UNLOCKED;
                    lock_cnt_next = '0;
                    rr_last_next  = 1'b1;
                end else if (!lock1) begin
                    state_next    = UNLOCKED;
                    lock_cnt_next = '0;
                end
            end
            default: begin
                state_next    = UNLOCKED;
                lock_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
            rr_last  <= 1'b1;
        end else begin
            state    <= state_next;
            lock_cnt <= lock_cnt_next;
            rr_last  <= rr_last_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            err0    <= gnt0 & mis0;
            err1    <= gnt1 & mis1;
            if (gnt0) begin
                rdata0 <= (we0 | mis0) ? '0 : mem_rd_data;
            end
            if (gnt1) begin
                rdata1 <= (we1 | mis1) ? '0 : mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory, ownership-level reference model,
// directed scenarios followed by randomized two-port traffic.
module tb_dmem_arbiter;

    localparam int LM = 4;

    logic        clk, reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [2:0]  funct3_0, funct3_1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_wr_en;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .funct3_0(funct3_0), .funct3_1(funct3_1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cb(input string name, input logic act, input logic exp);
        cw(name, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [7:0] b0, b1, b2, b3);
        case (f3)
            3'b000:  ext = {{24{b0[7]}}, b0};
            3'b001:  ext = {{16{b1[7]}}, b1, b0};
            3'b100:  ext = {24'h0, b0};
            3'b101:  ext = {16'h0, b1, b0};
            default: ext = {b3, b2, b1, b0};
        endcase
    endfunction

    function automatic logic misal(input logic [2:0] f3, input logic [31:0] a);
        misal = ((f3 == 3'b001 || f3 == 3'b101) && a[0] == 1'b1) ||
                (f3 == 3'b010 && a[1:0] != 2'b00);
    endfunction

    // Memory seen by the DUT: combinational read, byte-lane write on posedge.
    logic [7:0] bmem [256];
    logic [7:0] ba0, ba1, ba2, ba3;
    always_comb begin
        ba0 = mem_addr[7:0];
        ba1 = ba0 + 8'd1;
        ba2 = ba0 + 8'd2;
        ba3 = ba0 + 8'd3;
        mem_rd_data = ext(mem_funct3, bmem[ba0], bmem[ba1], bmem[ba2], bmem[ba3]);
    end
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) bmem[i] <= 8'h00;
        end else if (mem_wr_en) begin
            bmem[ba0] <= mem_wr_data[7:0];
            if (mem_funct3[1:0] != 2'b00) bmem[ba1] <= mem_wr_data[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                bmem[ba2] <= mem_wr_data[23:16];
                bmem[ba3] <= mem_wr_data[31:24];
            end
        end
    end

    // Reference model: the memory contents as a list of bytes, the current
    // owner (-1 = none), ownership cycles used, and the last winner.
    logic [7:0]  mmem [256];
    int          owner = -1;
    int          held  = 0;
    int          last  = 1;
    logic        e_rv0 = 1'b0, e_rv1 = 1'b0, e_er0 = 1'b0, e_er1 = 1'b0;
    logic [31:0] e_rd0 = '0, e_rd1 = '0;

    function automatic logic [31:0] mload(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0] i;
        i = a[7:0];
        mload = ext(f3, mmem[i], mmem[8'(i + 8'd1)], mmem[8'(i + 8'd2)], mmem[8'(i + 8'd3)]);
    endfunction

    task automatic mstore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) mmem[8'(a[7:0] + 8'(k))] = d[8*k +: 8];
    endtask

    initial begin
        forever begin
            int          w;
            logic [2:0]  f3;
            logic [31:0] a, wd, ld;
            logic        we_w, lk, mis, eg0, eg1, ewe, own_lock;
            logic [2:0]  ef3;
            logic [31:0] ea, ewd;
            @(negedge clk);
            cb("rvalid0", rvalid0, e_rv0);
            cb("rvalid1", rvalid1, e_rv1);
            cb("err0", err0, e_er0);
            cb("err1", err1, e_er1);
            cw("rdata0", rdata0, e_rd0);
            cw("rdata1", rdata1, e_rd1);

            w = -1;
            if (!reset) begin
                if (owner < 0) begin
                    if (req0 && req1) w = (last == 0) ? 1 : 0;
                    else if (req0) w = 0;
                    else if (req1) w = 1;
                end else if ((owner == 0 && req0) || (owner == 1 && req1)) begin
                    w = owner;
                end
            end
            if (w == 0) begin
                f3 = funct3_0; a = addr0; wd = wdata0; we_w = we0; lk = lock0;
            end else begin
                f3 = funct3_1; a = addr1; wd = wdata1; we_w = we1; lk = lock1;
            end
            mis = misal(f3, a);
            eg0 = 1'b0; eg1 = 1'b0; ewe = 1'b0; ef3 = 3'b010; ea = '0; ewd = '0;
            if (w >= 0) begin
                eg0 = (w == 0); eg1 = (w == 1);
                ewe = we_w && !mis; ef3 = f3; ea = a; ewd = wd;
            end
            cb("gnt0", gnt0, eg0);
            cb("gnt1", gnt1, eg1);
            cb("mem_wr_en", mem_wr_en, ewe);
            cw("mem_funct3", {29'b0, mem_funct3}, {29'b0, ef3});
            cw("mem_addr", mem_addr, ea);
            cw("mem_wr_data", mem_wr_data, ewd);

            e_rv0 = 1'b0; e_rv1 = 1'b0; e_er0 = 1'b0; e_er1 = 1'b0;
            if (reset) begin
                e_rd0 = '0; e_rd1 = '0;
                owner = -1; held = 0; last = 1;
                for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
            end else begin
                if (w >= 0) begin
                    ld = (!we_w && !mis) ? mload(f3, a) : 32'h0;
                    if (w == 0) begin e_rv0 = 1'b1; e_er0 = mis; e_rd0 = ld; end
                    else        begin e_rv1 = 1'b1; e_er1 = mis; e_rd1 = ld; end
                    if (we_w && !mis) mstore(f3, a, wd);
                    last = w;
                end
                if (owner >= 0) begin
                    own_lock = (owner == 0) ? lock0 : lock1;
                    held = held + 1;
                    if (held >= LM) begin
                        last  = owner;
                        owner = -1;
                    end else if (!own_lock) begin
                        owner = -1;
                    end
                end else if (w >= 0 && lk && LM > 1) begin
                    owner = w;
                    held  = 1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; we0 = 0; funct3_0 = 3'b010; addr0 = '0; wdata0 = '0; lock0 = 0;
        req1 = 0; we1 = 0; funct3_1 = 3'b010; addr1 = '0; wdata1 = '0; lock1 = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic set0(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic l);
        req0 = r; we0 = w; funct3_0 = f; addr0 = a; wdata0 = d; lock0 = l;
    endtask

    task automatic set1(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic l);
        req1 = r; we1 = w; funct3_1 = f; addr1 = a; wdata1 = d; lock1 = l;
    endtask

    // Randomized requester: holds its fields until granted, may withdraw.
    task automatic nxt(input logic g, inout logic pend, inout logic r, inout logic w,
                       inout logic [2:0] f, inout logic [31:0] a, inout logic [31:0] d,
                       inout logic l);
        if (pend && g) pend = 1'b0;
        if (pend && $urandom_range(0, 31) == 0) pend = 1'b0;
        if (!pend && $urandom_range(0, 1) == 1) begin
            pend = 1'b1;
            w = ($urandom_range(0, 2) == 0);
            if (w) f = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f = 3'b000;
                    1: f = 3'b001;
                    2: f = 3'b010;
                    3: f = 3'b100;
                    default: f = 3'b101;
                endcase
            end
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            d = $urandom;
            l = ($urandom_range(0, 1) == 1);
        end
        if (!pend) l = ($urandom_range(0, 3) == 0);
        r = pend;
    endtask

    logic seq_g0 [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic seq_g1 [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        logic p0, p1, g0, g1;
        reset = 1'b1;
        idle();
        do_reset();

        // Store then load the same word on port 0.
        set0(1, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        @(negedge clk); cb("t1 gnt0 sw", gnt0, 1); cb("t1 wr_en", mem_wr_en, 1);
        cyc(); set0(1, 0, 3'b010, 32'h10, 32'h0, 0);
        @(negedge clk); cb("t1 gnt0 lw", gnt0, 1); cb("t1 sw rvalid0", rvalid0, 1);
        cyc(); idle();
        @(negedge clk); cb("t1 rvalid0", rvalid0, 1); cw("t1 rdata0", rdata0, 32'hDEADBEEF);
        cb("t1 err0", err0, 0);

        // Continuous contention from reset alternates starting with port 0.
        cyc(); do_reset();
        set0(1, 0, 3'b010, 32'h0, 32'h0, 0);
        set1(1, 0, 3'b010, 32'h4, 32'h0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cb("t2 gnt0 alt", gnt0, seq_g0[i]);
            cb("t2 gnt1 alt", gnt1, ~seq_g0[i]);
            cyc();
        end

        // Signed and unsigned byte loads on port 1.
        idle(); do_reset();
        set1(1, 1, 3'b010, 32'h10, 32'h80FF0000, 0);
        @(negedge clk); cyc(); set1(1, 0, 3'b000, 32'h13, 32'h0, 0);
        @(negedge clk); cyc(); set1(1, 0, 3'b100, 32'h13, 32'h0, 0);
        @(negedge clk); cw("t3 lb", rdata1, 32'hFFFFFF80);
        cyc(); idle();
        @(negedge clk); cw("t3 lbu", rdata1, 32'h00000080);

        // Misaligned halfword store is suppressed and flagged.
        cyc(); set0(1, 1, 3'b010, 32'h20, 32'h11223344, 0);
        @(negedge clk); cyc(); set0(1, 1, 3'b001, 32'h21, 32'h1234, 0);
        @(negedge clk); cb("t4 gnt0", gnt0, 1); cb("t4 wr_en", mem_wr_en, 0);
        cyc(); set0(1, 0, 3'b010, 32'h20, 32'h0, 0);
        @(negedge clk); cb("t4 err0", err0, 1); cw("t4 rdata0", rdata0, 32'h0);
        cyc(); idle();
        @(negedge clk); cw("t4 word", rdata0, 32'h11223344); cb("t4 err0 clr", err0, 0);

        // Port 0 lock blocks port 1 until lock0 drops.
        cyc(); do_reset();
        set1(1, 0, 3'b010, 32'h4, 32'h0, 0);
        set0(1, 0, 3'b010, 32'h8, 32'h0, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); cb("t5 gnt0 locked", gnt0, 1); cb("t5 gnt1 blocked", gnt1, 0);
            cyc();
        end
        set0(0, 0, 3'b010, 32'h8, 32'h0, 0);
        @(negedge clk); cb("t5 gnt1 release cyc", gnt1, 0);
        cyc();
        @(negedge clk); cb("t5 gnt1 after", gnt1, 1);

        // Lock held at LOCK_MAX is forced off, then reset mid-sequence.
        cyc(); idle(); do_reset();
        set1(1, 0, 3'b010, 32'hC, 32'h0, 1);
        @(negedge clk); cb("t6 gnt1 first", gnt1, 1);
        cyc(); set0(1, 0, 3'b010, 32'h8, 32'h0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cb("t6 gnt1 seq", gnt1, seq_g1[i]);
            cb("t6 gnt0 seq", gnt0, ~seq_g1[i]);
            cyc();
        end
        reset = 1'b1;
        @(negedge clk); cb("t6 rst gnt0", gnt0, 0); cb("t6 rst gnt1", gnt1, 0);
        cb("t6 rst wr_en", mem_wr_en, 0); cw("t6 rst addr", mem_addr, 32'h0);
        cyc(); reset = 1'b0;
        @(negedge clk); cb("t6 rvalid1 cancel", rvalid1, 0); cw("t6 rdata1 rst", rdata1, 32'h0);
        cb("t6 unlocked gnt0", gnt0, 1);

        // Randomized traffic.
        cyc(); idle(); do_reset();
        p0 = 1'b0; p1 = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            g0 = gnt0; g1 = gnt1;
            @(posedge clk); #1;
            reset = ($urandom_range(0, 199) == 0);
            nxt(g0, p0, req0, we0, funct3_0, addr0, wdata0, lock0);
            nxt(g1, p1, req1, we1, funct3_1, addr1, wdata1, lock1);
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
